rename_retire_ctrl: RTL

//  In-order retirement sequencer for the renaming register file.
//  - Records each physical name as it is allocated, in program order, and hands back a queue tag.
//  - Accepts out-of-order writeback-complete marks by tag.
//  - Drives the rename file's free port (NAME_F/FE) strictly in allocation order, once the

---
 rtl/rename_retire_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/rename_retire_ctrl.sv
// In-order retirement sequencer: records allocated physical names, takes out-of-order
// writeback marks by tag, and frees names through NAME_F/FE strictly in allocation order.
// Latency: a WB to the head in cycle t retires it at the t+1 edge, so FE is high during t+2.
// Backpressure: ALLOC_READY drops when full; HOLD stalls retirement.
// Optional macro RETIRE_STALL_CNT_EN builds the head-blocked cycle counter on STALL_CNT.
module rename_retire_ctrl #(
  parameter int name_width = 1,
  parameter int tag_width  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ALLOC_E,
  input  logic [name_width-1:0] ALLOC_NAME,
  output logic                  ALLOC_READY,
  output logic [tag_width-1:0]  ALLOC_TAG,
  input  logic                  WB_E,
  input  logic [tag_width-1:0]  WB_TAG,
  input  logic                  HOLD,
  output logic [name_width-1:0] NAME_F,
  output logic                  FE,
  output logic [tag_width:0]    COUNT,
  output logic [31:0]           STALL_CNT
);

  localparam int DEPTH = 1 << tag_width;
  localparam logic [tag_width:0] full_cnt = DEPTH[tag_width:0];

  typedef logic [tag_width-1:0] tag_t;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [tag_width:0]  head;
  logic [tag_width:0]  tail;
  logic [DEPTH-1:0]    valid;
  logic [DEPTH-1:0]    done;
  logic [name_width-1:0] name_mem [DEPTH];

  tag_t head_idx;
  tag_t tail_idx;
  logic retire;
  logic alloc_ok;

  // Derived control: occupancy, readiness, retire and enqueue qualifiers.
  always_comb begin
    head_idx    = head[tag_width-1:0];
    tail_idx    = tail[tag_width-1:0];
    COUNT       = tail - head;
    ALLOC_READY = (COUNT != full_cnt);
    ALLOC_TAG   = tail_idx;
    retire      = valid[head_idx] && done[head_idx] && !HOLD;
    alloc_ok    = ALLOC_E && ALLOC_READY;
  end

  // Pointer advance and free-port output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head   <= '0;
      tail   <= '0;
      FE     <= 1'b0;
      NAME_F <= '0;
    end else begin
      if (alloc_ok) tail <= tail + 1'b1;
      if (retire) begin
        head   <= head + 1'b1;
        FE     <= 1'b1;
        NAME_F <= name_mem[head_idx];
      end else begin
        FE     <= 1'b0;
      end
    end
  end

  // Per-entry valid/done. Retire clearing the head wins over a late WB to the same entry;
  // an allocating index is never valid, so a WB to it is already ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
      done  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (retire && (tag_t'(i) == head_idx)) begin
          valid[i] <= 1'b0;
          done[i]  <= 1'b0;
        end else if (alloc_ok && (tag_t'(i) == tail_idx)) begin
          valid[i] <= 1'b1;
          done[i]  <= 1'b0;
        end else if (WB_E && (tag_t'(i) == WB_TAG) && valid[i]) begin
          done[i]  <= 1'b1;
        end
      end
    end
  end

  // Name storage needs no reset: a name is only read after its entry was written.
  always_ff @(posedge CLK) begin
    if (alloc_ok) name_mem[tail_idx] <= ALLOC_NAME;
  end

`ifdef RETIRE_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where the queue is occupied but the head cannot retire; saturates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
    end else if ((COUNT != '0) && !retire && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign STALL_CNT = stall_q;
`else
  assign STALL_CNT = 32'd0;
`endif

endmodule
